// File: rtl/rv32i_fetch_pkg.sv
// Shared definitions for the RV32I front end: fetch sequencer states,
// the canonical NOP encoding and base opcode values for decode/execute.
package rv32i_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/rv32i_fetch.sv
// Instruction fetch / issue sequencer. Fetches the word at the register
// file's PC, strobes the PC increment on a good ack, gives the register
// file one cycle to read rs1/rs2, then offers the instruction to execute.
// A redirect from execute throws away whatever is in flight.
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [XLEN-1:0]     pc_i,
  output logic                mem_req_o,
  output logic [XLEN-1:0]     mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_data_i,
  output logic                increment_pc_o,
  output logic [REG_BITS-1:0] rs1_addr_o,
  output logic [REG_BITS-1:0] rs2_addr_o,
  output logic [REG_BITS-1:0] rd_addr_o,
  output logic [31:0]         ir_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  input  logic                redirect_i
);

  fetch_state_e    state;
  logic [XLEN-1:0] drain_addr;

  // Sequencer: state, registered request/valid strobes and the fetched word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      mem_req_o     <= 1'b0;
      issue_valid_o <= 1'b0;
      ir_o          <= NOP_INSN;
      inst_pc_o     <= '0;
      drain_addr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          mem_req_o <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect_i) begin
            // Acked data is simply dropped and a fresh fetch starts from the
            // new PC; an outstanding request must be held until it completes.
            if (!mem_ack_i) begin
              drain_addr <= pc_i;
              state      <= ST_DRAIN;
            end
          end else if (mem_ack_i) begin
            ir_o      <= mem_data_i;
            inst_pc_o <= pc_i;
            mem_req_o <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (redirect_i) begin
            mem_req_o <= 1'b1;
            state     <= ST_FETCH;
          end else begin
            issue_valid_o <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A redirect coinciding with ready still counts as an accept.
          if (redirect_i || issue_ready_i) begin
            issue_valid_o <= 1'b0;
            mem_req_o     <= 1'b1;
            state         <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (mem_ack_i) state <= ST_FETCH;
        end
        default: begin
          mem_req_o     <= 1'b0;
          issue_valid_o <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus address follows the live PC except while draining an aborted fetch
  always_comb begin
    mem_addr_o = (state == ST_DRAIN) ? drain_addr : pc_i;
  end

  // PC increment fires in the ack cycle of a fetch that is being kept
  always_comb begin
    increment_pc_o = (state == ST_FETCH) && mem_ack_i && !redirect_i;
  end

  // Register-file addresses are raw instruction fields
  always_comb begin
    rs1_addr_o = ir_o[15 +: REG_BITS];
    rs2_addr_o = ir_o[20 +: REG_BITS];
    rd_addr_o  = ir_o[7 +: REG_BITS];
  end

endmodule
